// File: rtl/axis_video_frame_gen_pkg.sv
// Shared AXI4-Stream types plus the video generator's pattern and state enums.
package axis_pkg;

    // Output stream shape: n = tdata bytes, user_w = tuser bits.
    typedef struct packed {
        logic [7:0] n;
        logic [7:0] user_w;
    } axis_cfg_t;

    localparam axis_cfg_t AXIS_DEFAULT_CFG = '{n: 8'd2, user_w: 8'd1};

    typedef enum logic [1:0] {
        DIAG  = 2'd0,
        XRAMP = 2'd1,
        YRAMP = 2'd2,
        SOLID = 2'd3
    } video_pattern_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } vid_gen_state_t;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI4-Stream bundle; a beat transfers on a clock edge where tvalid && tready,
// and a master holding tvalid must keep tdata/tkeep/tlast/tuser stable until then.
interface axis_if #(
    parameter int N      = 2,
    parameter int USER_W = 1
) ();
    logic              tvalid;
    logic              tready;
    logic [N*8-1:0]    tdata;
    logic [N-1:0]      tkeep;
    logic              tlast;
    logic [USER_W-1:0] tuser;

    modport master (output tvalid, output tdata, output tkeep, output tlast, output tuser,
                    input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, input tuser,
                    output tready);
endinterface

// File: rtl/axis_video_frame_gen_lanes.sv
// Combinational pixel generator: PPC lanes starting at pixel x of line y.
module video_pattern_lanes
    import axis_pkg::*;
#(
    parameter int PPC = 2,
    parameter int BPP = 8,
    parameter int AW  = 16
) (
    input  logic [AW-1:0]      x_i,
    input  logic [AW-1:0]      y_i,
    input  logic [AW-1:0]      frame_idx_i,
    input  video_pattern_t     mode_i,
    input  logic [BPP-1:0]     solid_pixel_i,
    output logic [PPC*BPP-1:0] data_o
);

    // Arithmetic is done in BPP bits on zero-extended/truncated operands, which
    // yields the true sum modulo 2^BPP whatever the relation of BPP and AW.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < PPC; k++) begin
            case (mode_i)
                DIAG:    data_o[k*BPP +: BPP] = BPP'(x_i) + BPP'(k) + BPP'(y_i) + BPP'(frame_idx_i);
                XRAMP:   data_o[k*BPP +: BPP] = BPP'(x_i) + BPP'(k);
                YRAMP:   data_o[k*BPP +: BPP] = BPP'(y_i);
                default: data_o[k*BPP +: BPP] = solid_pixel_i;
            endcase
        end
    end

endmodule

// File: rtl/axis_video_frame_gen.sv
// AXI4-Stream video test-pattern source: whole frames, PPC pixels per beat.
// The beat register is loaded only on start or handshake, so content is stable
// under backpressure; tvalid is decoded from state so reset drops it at once.
module axis_video_frame_gen
    import axis_pkg::*;
#(
    parameter axis_cfg_t CONFIG = AXIS_DEFAULT_CFG,
    parameter int        PPC    = 2,
    parameter int        BPP    = 8,
    parameter int        AW     = 16
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic           start,
    input  logic           stop,
    input  logic [AW-1:0]  frame_width,
    input  logic [AW-1:0]  frame_height,
    input  logic [AW-1:0]  num_frames,
    input  logic [1:0]     mode,
    input  logic [BPP-1:0] solid_pixel,
    output logic           busy,
    output logic           done,
    output logic           cfg_err,
    output logic [AW-1:0]  frames_sent,
    axis_if.master         axis_out
);

    localparam int            DW     = int'(CONFIG.n) * 8;
    localparam int            UW     = int'(CONFIG.user_w);
    localparam logic [AW-1:0] PPC_AW = AW'(PPC);

    vid_gen_state_t     state_q, state_d;
    logic [AW-1:0]      width_q, width_d, height_q, height_d, nframes_q, nframes_d;
    video_pattern_t     mode_q, mode_d;
    logic [BPP-1:0]     solid_q, solid_d;
    logic [AW-1:0]      x_q, x_d, y_q, y_d, fidx_q, fidx_d, fsent_q, fsent_d;
    logic               stop_seen_q, stop_seen_d;
    logic [PPC*BPP-1:0] beat_q, beat_d, pat_data;
    logic               sof_q, sof_d, last_q, last_d;
    logic               cfg_err_q, cfg_err_d;

    logic cfg_ok, start_acc, hs, line_end, frame_end, last_frame, exit_run;

    assign cfg_ok     = (frame_width != '0) && (frame_height != '0) && ((frame_width % PPC_AW) == '0);
    assign start_acc  = (state_q == IDLE) && start && cfg_ok;
    assign hs         = (state_q == RUN) && axis_out.tready;
    assign line_end   = (x_q == width_q - PPC_AW);
    assign frame_end  = line_end && (y_q == height_q - AW'(1));
    assign last_frame = (nframes_q != '0) && ((fidx_q + AW'(1)) == nframes_q);
    assign exit_run   = hs && frame_end && (stop_seen_q || stop || last_frame);

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc) state_d = RUN;
            RUN:     if (exit_run)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        axis_out.tvalid = (state_q == RUN);
        busy            = (state_q == RUN);
        done            = (state_q == DONE);
    end

    // Config latch, coordinate/frame counters and next beat contents.
    always_comb begin
        width_d     = width_q;
        height_d    = height_q;
        nframes_d   = nframes_q;
        mode_d      = mode_q;
        solid_d     = solid_q;
        x_d         = x_q;
        y_d         = y_q;
        fidx_d      = fidx_q;
        fsent_d     = fsent_q;
        stop_seen_d = stop_seen_q || ((state_q == RUN) && stop);
        cfg_err_d   = (state_q == IDLE) && start && !cfg_ok;
        if (start_acc) begin
            width_d     = frame_width;
            height_d    = frame_height;
            nframes_d   = num_frames;
            mode_d      = video_pattern_t'(mode);
            solid_d     = solid_pixel;
            x_d         = '0;
            y_d         = '0;
            fidx_d      = '0;
            fsent_d     = '0;
            stop_seen_d = 1'b0;
        end else if (hs) begin
            if (!line_end) begin
                x_d = x_q + PPC_AW;
            end else begin
                x_d = '0;
                if (!frame_end) begin
                    y_d = y_q + AW'(1);
                end else begin
                    y_d         = '0;
                    fidx_d      = fidx_q + AW'(1);
                    fsent_d     = fsent_q + AW'(1);
                    stop_seen_d = 1'b0;
                end
            end
        end
        beat_d = (start_acc || hs) ? pat_data : beat_q;
        sof_d  = (start_acc || hs) ? ((x_d == '0) && (y_d == '0)) : sof_q;
        last_d = (start_acc || hs) ? (x_d == width_d - PPC_AW) : last_q;
    end

    video_pattern_lanes #(.PPC(PPC), .BPP(BPP), .AW(AW)) u_lanes (
        .x_i           (x_d),
        .y_i           (y_d),
        .frame_idx_i   (fidx_d),
        .mode_i        (mode_d),
        .solid_pixel_i (solid_d),
        .data_o        (pat_data)
    );

    // Datapath registers; reset abandons any in-flight frame.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            width_q     <= '0;
            height_q    <= '0;
            nframes_q   <= '0;
            mode_q      <= DIAG;
            solid_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            fidx_q      <= '0;
            fsent_q     <= '0;
            stop_seen_q <= 1'b0;
            beat_q      <= '0;
            sof_q       <= 1'b0;
            last_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            width_q     <= width_d;
            height_q    <= height_d;
            nframes_q   <= nframes_d;
            mode_q      <= mode_d;
            solid_q     <= solid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            fidx_q      <= fidx_d;
            fsent_q     <= fsent_d;
            stop_seen_q <= stop_seen_d;
            beat_q      <= beat_d;
            sof_q       <= sof_d;
            last_q      <= last_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign cfg_err         = cfg_err_q;
    assign frames_sent     = fsent_q;
    assign axis_out.tdata  = DW'(beat_q);
    assign axis_out.tkeep  = '1;
    assign axis_out.tlast  = last_q;
    assign axis_out.tuser  = UW'(sof_q);

endmodule

// File: tb/tb_axis_video_frame_gen.sv
// Bench for axis_video_frame_gen: randomized backpressure and configs against
// a frame-by-frame pixel model built with plain loops.
module tb_axis_video_frame_gen;
    import axis_pkg::*;

    localparam int PPC = 2;
    localparam int BPP = 8;
    localparam int AW  = 16;
    localparam int DW  = 16;

    logic           aclk = 1'b0;
    logic           areset;
    logic           start;
    logic           stop;
    logic [AW-1:0]  frame_width;
    logic [AW-1:0]  frame_height;
    logic [AW-1:0]  num_frames;
    logic [1:0]     mode;
    logic [BPP-1:0] solid_pixel;
    logic           busy, done, cfg_err;
    logic [AW-1:0]  frames_sent;

    axis_if #(.N(2), .USER_W(1)) axo ();

    axis_video_frame_gen #(.CONFIG(AXIS_DEFAULT_CFG), .PPC(PPC), .BPP(BPP), .AW(AW)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .start        (start),
        .stop         (stop),
        .frame_width  (frame_width),
        .frame_height (frame_height),
        .num_frames   (num_frames),
        .mode         (mode),
        .solid_pixel  (solid_pixel),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .frames_sent  (frames_sent),
        .axis_out     (axo)
    );

    // Clock.
    always #5 aclk = ~aclk;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] exp_q[$];
    logic          exp_sof_q[$];
    logic          exp_last_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    // Pixel value straight from the pattern definitions.
    function automatic logic [BPP-1:0] ref_pix(int m, int x, int y, int f, int solid);
        case (m)
            0:       return BPP'((x + y + f) % 256);
            1:       return BPP'(x % 256);
            2:       return BPP'(y % 256);
            default: return BPP'(solid);
        endcase
    endfunction

    // Append nf whole frames of expected beats.
    task automatic build_frames(input int w, input int h, input int nf, input int m, input int solid);
        for (int f = 0; f < nf; f++)
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x += PPC) begin
                    logic [DW-1:0] d;
                    d = '0;
                    for (int k = 0; k < PPC; k++)
                        d = d | (DW'(ref_pix(m, x + k, y, f, solid)) << (k * BPP));
                    exp_q.push_back(d);
                    exp_sof_q.push_back(x == 0 && y == 0);
                    exp_last_q.push_back(x == w - PPC);
                end
    endtask

    // Drive a start pulse; returns at the negedge where beat 0 should be visible.
    task automatic do_start(input int w, input int h, input int nf, input int m, input int solid);
        @(negedge aclk);
        frame_width  = AW'(w);
        frame_height = AW'(h);
        num_frames   = AW'(nf);
        mode         = 2'(m);
        solid_pixel  = BPP'(solid);
        start        = 1'b1;
        @(negedge aclk);
        start        = 1'b0;
    endtask

    // Consume the expected queue beat by beat, then check the done pulse.
    task automatic run_frames(input int stall_pct, input int stop_beat, input int exp_fs);
        int beats = 0;
        int cyc   = 0;
        while (exp_q.size() > 0 && cyc < 4000) begin
            check("tvalid", 32'(axo.tvalid), 32'd1);
            check("tdata",  32'(axo.tdata),  32'(exp_q[0]));
            check("sof",    32'(axo.tuser),  32'(exp_sof_q[0]));
            check("tlast",  32'(axo.tlast),  32'(exp_last_q[0]));
            check("tkeep",  32'(axo.tkeep),  32'h3);
            check("busy",   32'(busy),       32'd1);
            axo.tready = ($urandom_range(99) >= stall_pct);
            stop       = (beats == stop_beat);
            if (axo.tvalid && axo.tready) begin
                void'(exp_q.pop_front());
                void'(exp_sof_q.pop_front());
                void'(exp_last_q.pop_front());
                beats++;
            end
            @(negedge aclk);
            cyc++;
        end
        stop = 1'b0;
        check("beats_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        exp_sof_q.delete();
        exp_last_q.delete();
        check("done_pulse",  32'(done),        32'd1);
        check("done_tvalid", 32'(axo.tvalid),  32'd0);
        check("done_busy",   32'(busy),        32'd0);
        check("frames_sent", 32'(frames_sent), 32'(exp_fs));
        @(negedge aclk);
        check("done_clear",  32'(done),        32'd0);
        check("idle_tvalid", 32'(axo.tvalid),  32'd0);
        check("fs_hold",     32'(frames_sent), 32'(exp_fs));
    endtask

    task automatic check_cfg_err(input int w, input int h);
        do_start(w, h, 1, 1, 0);
        check("cfg_err_pulse",  32'(cfg_err),    32'd1);
        check("cfg_err_busy",   32'(busy),       32'd0);
        check("cfg_err_tvalid", 32'(axo.tvalid), 32'd0);
        @(negedge aclk);
        check("cfg_err_clear",  32'(cfg_err),    32'd0);
        check("cfg_err_tvalid2",32'(axo.tvalid), 32'd0);
    endtask

    initial begin
        areset = 1'b1; start = 1'b0; stop = 1'b0;
        frame_width = '0; frame_height = '0; num_frames = '0; mode = '0; solid_pixel = '0;
        axo.tready = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);

        // Reset state.
        check("rst_tvalid", 32'(axo.tvalid),  32'd0);
        check("rst_busy",   32'(busy),        32'd0);
        check("rst_done",   32'(done),        32'd0);
        check("rst_cfgerr", 32'(cfg_err),     32'd0);
        check("rst_fs",     32'(frames_sent), 32'd0);

        // Basic geometry, x ramp, no stalls.
        axo.tready = 1'b1;
        build_frames(8, 4, 1, 1, 0);
        do_start(8, 4, 1, 1, 0);
        check("beat0_const", 32'(axo.tdata), 32'h0100);
        run_frames(0, -1, 1);

        // Same frame under backpressure.
        build_frames(8, 4, 1, 1, 0);
        do_start(8, 4, 1, 1, 0);
        run_frames(30, -1, 1);

        // Multi-frame diagonal, back to back.
        build_frames(4, 2, 3, 0, 0);
        do_start(4, 2, 3, 0, 0);
        run_frames(0, -1, 3);

        // Continuous mode, stop during beat 5 of the second frame.
        build_frames(8, 4, 2, 2, 0);
        do_start(8, 4, 0, 2, 0);
        run_frames(20, 16 + 5, 2);

        // Rejected configurations.
        check_cfg_err(7, 4);
        check_cfg_err(0, 4);
        check_cfg_err(8, 0);

        // Reset in the middle of a frame.
        axo.tready = 1'b1;
        build_frames(8, 4, 1, 1, 0);
        do_start(8, 4, 1, 1, 0);
        repeat (6) begin
            void'(exp_q.pop_front());
            @(negedge aclk);
        end
        check("beat6_data", 32'(axo.tdata), 32'(exp_q[0]));
        exp_q.delete(); exp_sof_q.delete(); exp_last_q.delete();
        areset = 1'b1;
        #1;
        check("arst_tvalid", 32'(axo.tvalid), 32'd0);
        check("arst_busy",   32'(busy),       32'd0);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_tvalid", 32'(axo.tvalid),  32'd0);
        check("post_rst_done",   32'(done),        32'd0);
        check("post_rst_fs",     32'(frames_sent), 32'd0);
        check("post_rst_tlast",  32'(axo.tlast),   32'd0);
        build_frames(8, 4, 1, 1, 0);
        do_start(8, 4, 1, 1, 0);
        run_frames(0, -1, 1);

        // Random configurations; inputs scrambled while running must be ignored.
        for (int t = 0; t < 8; t++) begin
            int w, h, nf, m, s, st;
            w  = 2 * $urandom_range(1, 6);
            h  = $urandom_range(1, 4);
            nf = $urandom_range(1, 3);
            m  = $urandom_range(0, 3);
            s  = $urandom_range(0, 255);
            st = $urandom_range(0, 40);
            build_frames(w, h, nf, m, s);
            do_start(w, h, nf, m, s);
            frame_width  = AW'($urandom_range(1, 30));
            frame_height = AW'($urandom_range(1, 30));
            num_frames   = AW'($urandom_range(0, 5));
            mode         = 2'($urandom_range(0, 3));
            solid_pixel  = BPP'($urandom_range(0, 255));
            run_frames(st, -1, nf);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axis_video_frame_gen.md
Name: axis_video_frame_gen

Overview:
- Parametrised AXI4-Stream video test-pattern source: drives whole frames onto an axis_if master port for video-frame benches and DUT stimulus.
- Supports multiple pixels per clock, runtime frame geometry, four pattern modes, and finite or continuous frame counts.
- Obeys full tready backpressure.
- Frame markers: tuser[0] marks start of frame (SOF); tlast marks end of line (EOL).

Parameters:
- CONFIG, (axis_pkg default cfg), axis_cfg_t for the output stream; CONFIG.N*8 must be >= PPC*BPP.
- PPC, 2, pixels per beat (1..8).
- BPP, 8, bits per pixel.
- AW, 16, width of geometry, coordinate and frame counters.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous reset, active-high.
- start  in  1  pulse; latches config and begins generation when IDLE.
- stop  in  1  pulse; finish current frame, then return to IDLE.
- frame_width  in  AW  pixels per line.
- frame_height  in  AW  lines per frame.
- num_frames  in  AW  frames to send; 0 = continuous.
- mode  in  2  0 = diag (x+y+frame_idx), 1 = x ramp, 2 = y ramp, 3 = solid.
- solid_pixel  in  BPP  pixel value used in mode 3.
- busy  out  1  high from accepted start until DONE completes.
- done  out  1  one-cycle pulse after the last frame's final beat handshakes.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- frames_sent  out  AW  completed-frame count since last accepted start; wraps.
- axis_out  master  axis_if  uses tvalid, tready, tdata, tkeep, tlast, tuser.

Behaviour:
- Reset values: all outputs 0; all counters 0; state IDLE.
- Async assert: tvalid drops immediately; the in-flight frame is abandoned, with no completion.
- States: IDLE, RUN, DONE.
- IDLE:
  - start with width==0, height==0, or width%PPC!=0 -> cfg_err pulse, stay IDLE.
  - Otherwise latch width, height, num_frames, mode and solid_pixel; clear x, y, frame_idx and frames_sent.
  - Go to RUN; the first tvalid appears the next cycle (1-cycle start latency).
- RUN:
  - tvalid held high.
  - Registered output: when tvalid && !tready, tdata, tuser and tlast stay stable; the next beat is computed only on handshake.
- Beat content:
  - Lane k (k = 0..PPC-1) occupies tdata[k*BPP +: BPP] and carries pixel at x+k.
  - Pattern value is truncated to BPP bits.
  - tkeep = all ones.
  - tuser[0] = 1 only on beat x=0, y=0; other tuser bits 0.
  - tlast = 1 on beat x = width-PPC.
- Handshake advance:
  - x += PPC.
  - At line end: x = 0, y++.
  - At frame end: y = 0, frame_idx++, frames_sent++.
- Frame end exit conditions:
  - stop seen since the frame began, or frame_idx+1 == num_frames (num_frames != 0) -> DONE.
  - Otherwise the next frame starts back-to-back with no idle beat.
- stop:
  - Sticky until frame end; ignored in IDLE.
  - Takes effect at frame end only; a frame is never truncated.
- DONE: tvalid low, done pulse for one cycle, busy low, -> IDLE. frames_sent holds its value.
- start while busy: ignored. Input changes during RUN: ignored.
- Arithmetic:
  - x, y and frame_idx are AW bits; mode 0 sum is modulo 2^BPP.
  - Continuous mode: frame_idx wraps at 2^AW without stopping.

Decomposition:
- axis_pkg: add a video_pattern_t enum (DIAG, XRAMP, YRAMP, SOLID) and a vid_gen_state_t enum (IDLE, RUN, DONE).
- Sub-module video_pattern_lanes: purely combinational. Inputs: x, y, frame_idx, mode, solid_pixel. Output: PPC*BPP data word. Instantiated once.
- Top holds the FSM, counters and output register.

Test Plan:
- Basic geometry: PPC=2, BPP=8, width=8, height=4, num_frames=1, mode 1, tready=1.
  - 16 beats: beat 0 tdata=0x0100 with tuser=1; tlast on beats 3, 7, 11, 15.
  - done 1 cycle after beat 15; frames_sent=1.
- Backpressure: same config, tready pseudo-random 30% low.
  - tdata, tuser and tlast stable while stalled; identical beat sequence; no lost or duplicated beats.
- Multi-frame diag: mode 0, width=4, height=2, num_frames=3.
  - Frame 2 pixel (0,0) = 2; SOF on beats 0, 4, 8; frames back-to-back; frames_sent=3.
- Stop mid-frame: num_frames=0, stop pulsed on beat 5 of frame 1.
  - Frame 1 completes (16 beats); no SOF after it; done pulses; frames_sent=2.
- Config errors: start with width=7 (PPC=2), then width=0.
  - cfg_err pulse each time; busy stays 0; tvalid stays 0.
- Reset mid-frame: areset asserted on beat 6.
  - tvalid=0 the same cycle; after release, outputs 0; a new start restarts with SOF.
